// File: rtl/lut_neuron_cfg_loader_if.sv
// Config and lookup bundle for lut_neuron_cfg_loader; the loader sits on the slave modport.
interface lut_neuron_cfg_loader_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 1,
  parameter int CFG_W = 8
);
  logic             cfg_start;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;
  logic             table_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;

  modport master (
    output cfg_start, cfg_data, cfg_valid, in_data, in_valid,
    input  cfg_ready, cfg_done, cfg_err, table_valid, in_ready, out_data, out_valid
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid, in_data, in_valid,
    output cfg_ready, cfg_done, cfg_err, table_valid, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/lut_neuron_cfg_loader.sv
// Runtime-loadable truth-table neuron: serial beat loader plus registered table lookup.
// Define LUT_CFG_CHECKSUM_EN to require a trailing XOR checksum beat on every load.
module lut_neuron_cfg_loader #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 1,
  parameter int CFG_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  lut_neuron_cfg_loader_if.slave bus
);
  localparam int DEPTH  = 1 << IN_W;
  localparam int TBITS  = DEPTH * OUT_W;
  localparam int NBEATS = TBITS / CFG_W;
  localparam int BW     = (TBITS > 1) ? $clog2(TBITS) : 1;
  localparam int CW     = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t           state, state_n;
  logic [TBITS-1:0] tbl;
  logic [CW-1:0]    cnt;
  logic             load_start, beat_acc, load_ok, load_bad;
  logic             lookup_acc, last_data, wr_en;
  logic [BW-1:0]    wr_base, rd_base;
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q, cfg_done_q, cfg_err_q, table_valid_q;

  assign last_data  = (cnt == CW'(NBEATS - 1));
  assign lookup_acc = bus.in_valid && (state == READY);
  assign wr_base    = BW'(cnt) * BW'(CFG_W);
  assign rd_base    = BW'(bus.in_data) * BW'(OUT_W);

`ifdef LUT_CFG_CHECKSUM_EN
  logic [CFG_W-1:0] csum;
  logic             data_beat;
  assign data_beat = (cnt != CW'(NBEATS));
  assign wr_en     = beat_acc && data_beat;
`else
  assign wr_en     = beat_acc;
`endif

  // A cfg_start in LOADING takes priority over a beat presented in the same cycle.
  always_comb begin
    state_n    = state;
    load_start = 1'b0;
    beat_acc   = 1'b0;
    load_ok    = 1'b0;
    load_bad   = 1'b0;
    case (state)
      EMPTY: begin
        if (bus.cfg_start) begin
          state_n    = LOADING;
          load_start = 1'b1;
        end
      end
      LOADING: begin
        if (bus.cfg_start) begin
          load_start = 1'b1;
        end else if (bus.cfg_valid) begin
          beat_acc = 1'b1;
`ifdef LUT_CFG_CHECKSUM_EN
          if (!data_beat) begin
            if (bus.cfg_data == csum) begin
              load_ok = 1'b1;
              state_n = READY;
            end else begin
              load_bad = 1'b1;
              state_n  = EMPTY;
            end
          end
`else
          if (last_data) begin
            load_ok = 1'b1;
            state_n = READY;
          end
`endif
        end
      end
      READY: begin
        if (bus.cfg_start) begin
          state_n    = LOADING;
          load_start = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= EMPTY;
      cnt           <= '0;
      tbl           <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      cfg_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      table_valid_q <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state       <= state_n;
      cfg_done_q  <= load_ok;
      out_valid_q <= lookup_acc;
      if (lookup_acc) out_data_q <= tbl[rd_base +: OUT_W];
      if (load_start) begin
        cnt           <= '0;
        table_valid_q <= 1'b0;
        cfg_err_q     <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
        csum          <= '0;
`endif
      end else if (beat_acc) begin
        cnt <= cnt + CW'(1);
      end
      if (wr_en) begin
        tbl[wr_base +: CFG_W] <= bus.cfg_data;
`ifdef LUT_CFG_CHECKSUM_EN
        csum <= csum ^ bus.cfg_data;
`endif
      end
      if (load_ok)  table_valid_q <= 1'b1;
      if (load_bad) cfg_err_q     <= 1'b1;
    end
  end

  assign bus.cfg_ready   = (state == LOADING);
  assign bus.in_ready    = (state == READY);
  assign bus.cfg_done    = cfg_done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.table_valid = table_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_lut_neuron_cfg_loader.sv
// Directed bench for lut_neuron_cfg_loader; honours LUT_CFG_CHECKSUM_EN when defined.
module tb_lut_neuron_cfg_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  lut_neuron_cfg_loader_if #(.IN_W(6), .OUT_W(1), .CFG_W(8)) bus ();

  lut_neuron_cfg_loader #(.IN_W(6), .OUT_W(1), .CFG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Table A: entry = in[4] & in[0].  Table B: entry = (in[2:0] == in[5:3]).
  localparam logic [63:0] TAB_A = 64'hAAAA_0000_AAAA_0000;
  localparam logic [63:0] TAB_B = 64'h8040_2010_0804_0201;

  initial begin
    #100000;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL timeout: stimulus did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Sends the 8 data beats; with gap set, an idle cycle precedes every beat after the first.
  task automatic send_beats(input logic [63:0] w, input bit gap);
    for (int k = 0; k < 8; k++) begin
      if (gap && k != 0) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'h5A;
        tick();
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = w[k*8 +: 8];
      tick();
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [5:0] code, input logic exp);
    bus.in_valid = 1'b1;
    bus.in_data  = code;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_data"}, bus.out_data, exp);
    tick();
    check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [5:0] c;
    bus.cfg_start = 1'b0;
    bus.cfg_data  = '0;
    bus.cfg_valid = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.table_valid !== 1'b0) begin
      failures++;
      $error("FAIL rst_state in_ready=%0b cfg_ready=%0b table_valid=%0b",
             bus.in_ready, bus.cfg_ready, bus.table_valid);
    end
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 1'b0);
    check("rst_cfg_done", bus.cfg_done, 1'b0);
    check("rst_cfg_err", bus.cfg_err, 1'b0);

    // Lookup attempt and stray beat in EMPTY
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 6'h11;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'hFF;
    tick();
    check("empty_in_ready", bus.in_ready, 1'b0);
    check("empty_out_valid", bus.out_valid, 1'b0);
    check("empty_table_valid", bus.table_valid, 1'b0);
    check("empty_cfg_ready", bus.cfg_ready, 1'b0);
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;

    // Load table A
    start_load();
    check("load_cfg_ready", bus.cfg_ready, 1'b1);
    check("load_table_valid", bus.table_valid, 1'b0);
    send_beats(TAB_A, 1'b0);
`ifdef LUT_CFG_CHECKSUM_EN
    check("a_no_early_done", bus.cfg_done, 1'b0);
    send_beat(8'h00);
`endif
    check("a_cfg_done", bus.cfg_done, 1'b1);
    check("a_table_valid", bus.table_valid, 1'b1);
    check("a_in_ready", bus.in_ready, 1'b1);
    check("a_cfg_ready", bus.cfg_ready, 1'b0);
    tick();
    check("a_cfg_done_pulse", bus.cfg_done, 1'b0);
    check("a_cfg_err", bus.cfg_err, 1'b0);

    lookup("a_010001", 6'b010001, 1'b1);
    lookup("a_110011", 6'b110011, 1'b1);
    lookup("a_100001", 6'b100001, 1'b0);
    lookup("a_010000", 6'b010000, 1'b0);

    // Back-to-back sweep of all 64 codes
    for (int i = 0; i < 64; i++) begin
      c = 6'(i);
      bus.in_valid = 1'b1;
      bus.in_data  = c;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin
        failures++;
        $error("FAIL sweep_valid code=%0h observed=%0b", c, bus.out_valid);
      end
      checks++;
      if (bus.out_data !== (c[4] & c[0])) begin
        failures++;
        $error("FAIL sweep_data code=%0h observed=%0b expected=%0b", c, bus.out_data, c[4] & c[0]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    check("sweep_end_valid", bus.out_valid, 1'b0);
    check("sweep_hold_data", bus.out_data, 1'b1);

    // A beat offered in READY must not touch the table
    send_beat(8'hFF);
    check("ready_beat_tv", bus.table_valid, 1'b1);
    check("ready_beat_done", bus.cfg_done, 1'b0);
    lookup("ready_beat_e1", 6'h01, 1'b0);

    // cfg_start together with a lookup: old table answers, state moves to LOADING
    bus.cfg_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 6'h11;
    tick();
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    check("sim_out_valid", bus.out_valid, 1'b1);
    check("sim_out_data", bus.out_data, 1'b1);
    check("sim_in_ready", bus.in_ready, 1'b0);
    check("sim_cfg_ready", bus.cfg_ready, 1'b1);
    check("sim_table_valid", bus.table_valid, 1'b0);

    // Partial junk load, restart, then table B with gapped beats
    for (int k = 0; k < 4; k++) begin
      send_beat(8'hFF);
      tick();
    end
    start_load();
    check("restart_tv", bus.table_valid, 1'b0);
    check("restart_cfg_ready", bus.cfg_ready, 1'b1);
    send_beats(TAB_B, 1'b1);
`ifdef LUT_CFG_CHECKSUM_EN
    send_beat(8'hFF);
`endif
    check("b_cfg_done", bus.cfg_done, 1'b1);
    check("b_table_valid", bus.table_valid, 1'b1);
    tick();
    lookup("b_00", 6'o00, 1'b1);
    lookup("b_01", 6'o01, 1'b0);
    lookup("b_11", 6'o11, 1'b1);
    lookup("b_21", 6'o21, 1'b0);
    lookup("b_22", 6'o22, 1'b1);
    lookup("b_33", 6'o33, 1'b1);
    lookup("b_77", 6'o77, 1'b1);
    lookup("b_76", 6'o76, 1'b0);

`ifdef LUT_CFG_CHECKSUM_EN
    start_load();
    send_beats(TAB_A, 1'b0);
    send_beat(8'h01);
    check("ck_bad_err", bus.cfg_err, 1'b1);
    check("ck_bad_tv", bus.table_valid, 1'b0);
    check("ck_bad_done", bus.cfg_done, 1'b0);
    check("ck_bad_in_ready", bus.in_ready, 1'b0);
    start_load();
    check("ck_err_cleared", bus.cfg_err, 1'b0);
    send_beats(TAB_A, 1'b0);
    send_beat(8'h00);
    check("ck_good_done", bus.cfg_done, 1'b1);
    check("ck_good_tv", bus.table_valid, 1'b1);
    tick();
    lookup("ck_good_11", 6'h11, 1'b1);
`endif

    // Reset mid-load discards everything
    start_load();
    send_beat(8'hFF);
    rst = 1'b0;
    tick();
    check("rst2_table_valid", bus.table_valid, 1'b0);
    check("rst2_cfg_ready", bus.cfg_ready, 1'b0);
    check("rst2_out_data", bus.out_data, 1'b0);
    rst = 1'b1;
    tick();
    check("rst2_in_ready", bus.in_ready, 1'b0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
